video_stream_sink: RTL and testbench

- AXI4-Stream video slave: the receiving end of the pixel stream produced by our pixel generator.
- Consumes 32-bit pixels and tracks the (x,y) raster position.
- Checks framing: tuser marks start of frame (SOF); tlast marks end of line (EOL).
- Computes a per-frame checksum and keeps error/frame counters for on-chip self-checking and hardware bring-up.

---
 rtl/video_stream_sink.sv | 143 ++++++++++++++
 tb/tb_video_stream_sink.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_sink.sv
// AXI4-Stream video sink: tracks raster position, checks SOF/EOL framing,
// accumulates a rotate-xor checksum per frame and keeps error/frame counters.
module video_stream_sink #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  parameter int X_BITS = 10,
  parameter int Y_BITS = 9
) (
  input  logic              in_stream_aclk,
  input  logic              axi_resetn,
  input  logic [31:0]       in_stream_tdata,
  input  logic [3:0]        in_stream_tkeep,
  input  logic              in_stream_tlast,
  input  logic              in_stream_tvalid,
  input  logic              in_stream_tuser,
  output logic              in_stream_tready,
  input  logic              sink_enable,
  output logic [X_BITS-1:0] cur_x,
  output logic [Y_BITS-1:0] cur_y,
  output logic              frame_done,
  output logic [31:0]       frame_crc,
  output logic [15:0]       frame_count,
  output logic [7:0]        err_sof,
  output logic [7:0]        err_eol,
  output logic [7:0]        err_keep
);

  typedef enum logic {WAIT_SOF, RECV} state_t;

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_SIZE - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_SIZE - 1);

  state_t            state_q, state_d;
  logic              ready_q;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [31:0]       acc_q, acc_d;
  logic              frame_done_q, frame_done_d;
  logic [31:0]       frame_crc_q, frame_crc_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [7:0]        err_sof_q, err_sof_d;
  logic [7:0]        err_eol_q, err_eol_d;
  logic [7:0]        err_keep_q, err_keep_d;

  logic              beat, take, at_origin, frame_start, line_end, frame_end;
  logic [X_BITS-1:0] px;
  logic [Y_BITS-1:0] py;
  logic [31:0]       acc_next;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    acc_d         = acc_q;
    frame_done_d  = 1'b0;
    frame_crc_d   = frame_crc_q;
    frame_count_d = frame_count_q;
    err_sof_d     = err_sof_q;
    err_eol_d     = err_eol_q;
    err_keep_d    = err_keep_q;

    beat      = in_stream_tvalid && ready_q;
    at_origin = (x_q == '0) && (y_q == '0);
    // Beats in WAIT_SOF without tuser are dropped entirely.
    take      = beat && ((state_q == RECV) || in_stream_tuser);
    // Any tuser, or any beat landing on (0,0), (re)starts the frame.
    frame_start = (state_q == WAIT_SOF) || in_stream_tuser || at_origin;
    px        = frame_start ? '0 : x_q;
    py        = frame_start ? '0 : y_q;
    acc_next  = frame_start ? in_stream_tdata
                            : ({acc_q[30:0], acc_q[31]} ^ in_stream_tdata);
    line_end  = (px == X_LAST) || in_stream_tlast;
    frame_end = line_end && (py == Y_LAST);

    if (take) begin
      state_d = RECV;
      acc_d   = acc_next;
      if ((state_q == RECV) && (in_stream_tuser != at_origin))
        err_sof_d = sat_inc(err_sof_q);
      if (in_stream_tlast != (px == X_LAST))
        err_eol_d = sat_inc(err_eol_q);
      if (in_stream_tkeep != 4'hF)
        err_keep_d = sat_inc(err_keep_q);

      if (frame_end) begin
        x_d           = '0;
        y_d           = '0;
        frame_crc_d   = acc_next;
        frame_count_d = frame_count_q + 16'd1;
        frame_done_d  = 1'b1;
      end else if (line_end) begin
        x_d = '0;
        y_d = py + Y_BITS'(1);
      end else begin
        x_d = px + X_BITS'(1);
        y_d = py;
      end
    end
  end

  always_ff @(posedge in_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q       <= WAIT_SOF;
      ready_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      acc_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_crc_q   <= '0;
      frame_count_q <= '0;
      err_sof_q     <= '0;
      err_eol_q     <= '0;
      err_keep_q    <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= sink_enable;
      x_q           <= x_d;
      y_q           <= y_d;
      acc_q         <= acc_d;
      frame_done_q  <= frame_done_d;
      frame_crc_q   <= frame_crc_d;
      frame_count_q <= frame_count_d;
      err_sof_q     <= err_sof_d;
      err_eol_q     <= err_eol_d;
      err_keep_q    <= err_keep_d;
    end
  end

  assign in_stream_tready = ready_q;
  assign cur_x            = x_q;
  assign cur_y            = y_q;
  assign frame_done       = frame_done_q;
  assign frame_crc        = frame_crc_q;
  assign frame_count      = frame_count_q;
  assign err_sof          = err_sof_q;
  assign err_eol          = err_eol_q;
  assign err_keep         = err_keep_q;

endmodule

// File: tb/tb_video_stream_sink.sv
// Bench for video_stream_sink on a 4x2 raster: table-driven beats with a
// frame_done scoreboard, plus hand-written reset, stall and error sequences.
module tb_video_stream_sink;

  localparam int X_SIZE = 4;
  localparam int Y_SIZE = 2;
  localparam int X_BITS = 10;
  localparam int Y_BITS = 9;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
    logic [3:0]  keep;
    int          ex;
    int          ey;
    logic        push;
    logic [31:0] crc;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [31:0] crc;
    logic [15:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       tdata = '0;
  logic [3:0]        tkeep = 4'hF;
  logic              tlast = 1'b0;
  logic              tvalid = 1'b0;
  logic              tuser = 1'b0;
  logic              tready;
  logic              baseEn = 1'b0;
  logic              togEn = 1'b0;
  logic              toggleMode = 1'b0;
  logic              sink_enable;
  logic [X_BITS-1:0] cur_x;
  logic [Y_BITS-1:0] cur_y;
  logic              frame_done;
  logic [31:0]       frame_crc;
  logic [15:0]       frame_count;
  logic [7:0]        err_sof, err_eol, err_keep;

  int   nChecks = 0;
  int   nFail = 0;
  int   togCnt = 0;
  vec_t vecs[$];
  exp_t sbq[$];
  exp_t monE;

  assign sink_enable = toggleMode ? togEn : baseEn;

  video_stream_sink #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .X_BITS(X_BITS), .Y_BITS(Y_BITS)) dut (
    .in_stream_aclk  (clk),
    .axi_resetn      (rst_n),
    .in_stream_tdata (tdata),
    .in_stream_tkeep (tkeep),
    .in_stream_tlast (tlast),
    .in_stream_tvalid(tvalid),
    .in_stream_tuser (tuser),
    .in_stream_tready(tready),
    .sink_enable     (sink_enable),
    .cur_x           (cur_x),
    .cur_y           (cur_y),
    .frame_done      (frame_done),
    .frame_crc       (frame_crc),
    .frame_count     (frame_count),
    .err_sof         (err_sof),
    .err_eol         (err_eol),
    .err_keep        (err_keep)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    togCnt = togCnt + 1;
    if (togCnt == 2) begin
      togCnt = 0;
      togEn  = ~togEn;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks = nChecks + 1;
    if (act !== exp) begin
      nFail = nFail + 1;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Every frame_done pulse must match the next expected frame result.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (sbq.size() == 0) begin
        nChecks = nChecks + 1;
        nFail = nFail + 1;
        $display("[TB] FAIL frame_done: got unexpected pulse, want none");
      end else begin
        monE = sbq.pop_front();
        checkOutput("frame_crc", frame_crc, monE.crc);
        checkOutput("frame_count", 32'(frame_count), 32'(monE.cnt));
      end
    end
  end

  function automatic void addBeat(input logic [31:0] d, input logic u, input logic l,
                                  input logic [3:0] k, input int ex, input int ey,
                                  input logic p, input logic [31:0] c, input int n);
    vec_t v;
    v.data = d; v.user = u; v.last = l; v.keep = k;
    v.ex = ex; v.ey = ey; v.push = p; v.crc = c; v.cnt = n;
    vecs.push_back(v);
  endfunction

  // Pixels 1..8 give checksum 0x16 on a 4x2 raster.
  function automatic void addCleanFrame(input logic [3:0] k, input int n, input int nBeats);
    for (int i = 1; i <= nBeats; i++)
      addBeat(32'(i), i == 1, (i % 4) == 0, k, i % 4, (i / 4) % 2, i == 8, 32'h16, n);
  endfunction

  task automatic applyStimulus(input vec_t v);
    int waitCycles;
    waitCycles = 0;
    tdata = v.data; tuser = v.user; tlast = v.last; tkeep = v.keep; tvalid = 1'b1;
    while (tready !== 1'b1 && waitCycles < 50) begin
      @(negedge clk);
      waitCycles = waitCycles + 1;
    end
    if (tready !== 1'b1) begin
      nChecks = nChecks + 1;
      nFail = nFail + 1;
      $display("[TB] FAIL handshake: got tready=%b after 50 cycles, want 1", tready);
    end
    @(negedge clk);
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic runVectors();
    foreach (vecs[i]) begin
      if (vecs[i].push) begin
        exp_t e;
        e.crc = vecs[i].crc;
        e.cnt = 16'(vecs[i].cnt);
        sbq.push_back(e);
      end
      applyStimulus(vecs[i]);
      checkOutput("cur_x", 32'(cur_x), 32'(vecs[i].ex));
      checkOutput("cur_y", 32'(cur_y), 32'(vecs[i].ey));
    end
    vecs.delete();
    @(negedge clk);
    checkOutput("pending_frames", 32'(sbq.size()), 32'd0);
  endtask

  task automatic checkErrors(input int s, input int e, input int k);
    checkOutput("err_sof", 32'(err_sof), 32'(s));
    checkOutput("err_eol", 32'(err_eol), 32'(e));
    checkOutput("err_keep", 32'(err_keep), 32'(k));
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    tvalid = 1'b0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    baseEn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset held with tvalid high: nothing may be accepted, outputs all zero.
    tvalid = 1'b1;
    baseEn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tready", 32'(tready), 32'd0);
    checkOutput("rst_cur_x", 32'(cur_x), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_frame_crc", frame_crc, 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkErrors(0, 0, 0);
    rst_n = 1'b1;
    tvalid = 1'b0;
    checkOutput("rel_tready_early", 32'(tready), 32'd0);
    @(negedge clk);
    checkOutput("rel_tready", 32'(tready), 32'd1);

    // Clean frame.
    addCleanFrame(4'hF, 1, 8);
    runVectors();
    checkErrors(0, 0, 0);

    // Pre-SOF beats discarded, then a beat with no tuser at (0,0) after the frame.
    resetDut();
    for (int i = 0; i < 3; i++) addBeat(32'hAA, 1'b0, 1'b0, 4'hF, 0, 0, 1'b0, 32'h0, 0);
    addCleanFrame(4'hF, 1, 8);
    runVectors();
    checkErrors(0, 0, 0);
    addBeat(32'h55, 1'b0, 1'b0, 4'hF, 1, 0, 1'b0, 32'h0, 0);
    runVectors();
    checkErrors(1, 0, 0);

    // Early tlast on beat 3 realigns to the next line.
    resetDut();
    addBeat(32'd1, 1'b1, 1'b0, 4'hF, 1, 0, 1'b0, 32'h0, 0);
    addBeat(32'd2, 1'b0, 1'b0, 4'hF, 2, 0, 1'b0, 32'h0, 0);
    addBeat(32'd3, 1'b0, 1'b1, 4'hF, 0, 1, 1'b0, 32'h0, 0);
    addBeat(32'd4, 1'b0, 1'b0, 4'hF, 1, 1, 1'b0, 32'h0, 0);
    addBeat(32'd5, 1'b0, 1'b0, 4'hF, 2, 1, 1'b0, 32'h0, 0);
    addBeat(32'd6, 1'b0, 1'b0, 4'hF, 3, 1, 1'b0, 32'h0, 0);
    addBeat(32'd7, 1'b0, 1'b1, 4'hF, 0, 0, 1'b1, 32'hF, 1);
    runVectors();
    checkErrors(0, 1, 0);

    // Backpressure: sink_enable toggles every two cycles.
    resetDut();
    toggleMode = 1'b1;
    addCleanFrame(4'hF, 1, 8);
    runVectors();
    toggleMode = 1'b0;
    checkErrors(0, 0, 0);

    // Unexpected tuser mid-frame aborts the partial frame.
    resetDut();
    addCleanFrame(4'hF, 0, 5);
    addCleanFrame(4'hF, 1, 8);
    runVectors();
    checkErrors(1, 0, 0);

    // Asynchronous reset mid-frame clears everything without a clock edge.
    addCleanFrame(4'hF, 0, 3);
    runVectors();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_cur_x", 32'(cur_x), 32'd0);
    checkOutput("async_frame_count", 32'(frame_count), 32'd0);
    checkOutput("async_err_sof", 32'(err_sof), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    addCleanFrame(4'hF, 1, 8);
    runVectors();
    checkErrors(0, 0, 0);

    // Bad tkeep on every beat of 33 frames: pixels still processed, err_keep saturates.
    resetDut();
    for (int f = 1; f <= 33; f++) addCleanFrame(4'h0, f, 8);
    runVectors();
    checkErrors(0, 0, 255);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
